// File: rtl/sram_responder.sv
// sram_responder: behavioural model of an asynchronous-style SRAM chip, clocked.
// The bus pins are sampled on each rising clk edge, and every decision uses
// those sampled values. Writes are captured while ce_n/we_n are low. They are
// committed on the first cycle in which either strobe is released. Reads are
// served after READ_LAT cycles onto the shared ram_data bus.
//
// Handshake: a read request is ce_n=0, oe_n=0, we_n=1 held stable. The
// responder drives ram_data only while in READ_DRIVE. Dropping ce_n or oe_n
// releases the bus on the same edge. Changing the address restarts the
// latency count.
//
// Optional feature: define SRAM_RESP_CONFLICT_EN to build the sticky conflict
// detector. A cycle with ce_n=oe_n=we_n=0 sets it. Without the macro, conflict
// is tied to 0.
module sram_responder #(
    parameter int ADDR_W   = 8,
    parameter int READ_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    inout  wire  [31:0] ram_data,
    input  logic [19:0] ram_addr,
    input  logic [3:0]  ram_be_n,
    input  logic        ram_ce_n,
    input  logic        ram_oe_n,
    input  logic        ram_we_n,
    output logic [15:0] wr_count,
    output logic [15:0] rd_count,
    output logic        conflict,
    output logic [1:0]  state_dbg
);

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [1:0] LAT_LOAD = 2'(READ_LAT - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE      = 2'd1,
        READ_WAIT  = 2'd2,
        READ_DRIVE = 2'd3
    } state_t;

    state_t              state;
    logic [1:0]          lat_cnt;
    logic [19:0]         rd_addr;
    logic [ADDR_W-1:0]   wr_addr;
    logic [3:0]          wr_be_n;
    logic [31:0]         wr_data;
    logic                drive_en;
    logic [31:0]         mem [0:DEPTH-1];
    logic [31:0]         rd_word;

    logic wr_req;
    logic rd_req;
    logic rd_abort;
    logic commit;

    // Decode of the pin levels present at the coming edge.
    assign wr_req   = !ram_ce_n && !ram_we_n;
    assign rd_req   = !ram_ce_n && !ram_oe_n && ram_we_n;
    assign rd_abort = ram_ce_n || ram_oe_n;
    // A capture in progress is committed on the first edge with the strobes
    // released. Reset forces IDLE, so a pending write is simply dropped.
    assign commit   = rst && (state == WRITE) && !wr_req;

    assign state_dbg = state;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Control FSM: write capture/commit, read latency, bus drive and counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            lat_cnt  <= 2'd0;
            rd_addr  <= 20'd0;
            wr_addr  <= '0;
            wr_be_n  <= 4'hF;
            wr_data  <= 32'd0;
            drive_en <= 1'b0;
            wr_count <= 16'd0;
            rd_count <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    drive_en <= 1'b0;
                    if (wr_req) begin
                        state   <= WRITE;
                        wr_addr <= ram_addr[ADDR_W-1:0];
                        wr_be_n <= ram_be_n;
                        wr_data <= ram_data;
                    end else if (rd_req) begin
                        state   <= READ_WAIT;
                        lat_cnt <= LAT_LOAD;
                        rd_addr <= ram_addr;
                    end
                end
                WRITE: begin
                    drive_en <= 1'b0;
                    if (wr_req) begin
                        // Strobes still low: the last captured beat wins.
                        wr_addr <= ram_addr[ADDR_W-1:0];
                        wr_be_n <= ram_be_n;
                        wr_data <= ram_data;
                    end else begin
                        wr_count <= sat_inc(wr_count);
                        state    <= IDLE;
                    end
                end
                READ_WAIT, READ_DRIVE: begin
                    if (rd_abort || !ram_we_n) begin
                        // A write strobe during a read is picked up from IDLE
                        // on the following edge.
                        state    <= IDLE;
                        drive_en <= 1'b0;
                    end else if (ram_addr != rd_addr) begin
                        state    <= READ_WAIT;
                        lat_cnt  <= LAT_LOAD;
                        rd_addr  <= ram_addr;
                        drive_en <= 1'b0;
                    end else if (state == READ_WAIT) begin
                        if (lat_cnt == 2'd0) begin
                            state    <= READ_DRIVE;
                            drive_en <= 1'b1;
                            rd_count <= sat_inc(rd_count);
                        end else begin
                            lat_cnt <= lat_cnt - 2'd1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    drive_en <= 1'b0;
                end
            endcase
        end
    end

    // Storage: byte-masked commit, not cleared by reset.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (!wr_be_n[i]) begin
                    mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Read data is taken straight from storage, so an earlier commit is
    // always visible.
    assign rd_word  = mem[rd_addr[ADDR_W-1:0]];
    assign ram_data = drive_en ? rd_word : 32'hzzzz_zzzz;

`ifdef SRAM_RESP_CONFLICT_EN
    // Sticky flag for a cycle with output enable and write enable both asserted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conflict <= 1'b0;
        end else if (!ram_ce_n && !ram_oe_n && !ram_we_n) begin
            conflict <= 1'b1;
        end
    end
`else
    assign conflict = 1'b0;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder. Two instances share the control pins:
// dut1 has READ_LAT=1 and dut3 has READ_LAT=3. Each has its own data bus.
module tb_sram_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] addr;
    logic [3:0]  be_n;
    logic        ce_n;
    logic        oe_n;
    logic        we_n;
    logic [31:0] tb_d;
    logic        tb_den;
    wire  [31:0] bus1;
    wire  [31:0] bus3;

    logic [15:0] wr1, rd1, wr3, rd3;
    logic        conf1, conf3;
    logic [1:0]  st1, st3;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Each entry is {edge number at which the drive starts, data}.
    logic [47:0] exp1_q[$];
    logic [47:0] exp3_q[$];
    logic [47:0] e1, e3;
    logic [1:0]  prev1 = 2'd0;
    logic [1:0]  prev3 = 2'd0;

`ifdef SRAM_RESP_CONFLICT_EN
    localparam logic EXP_CONF = 1'b1;
`else
    localparam logic EXP_CONF = 1'b0;
`endif

    localparam logic [31:0] PROBE = 32'h5AA5_C33C;

    assign bus1 = tb_den ? tb_d : 32'hzzzz_zzzz;
    assign bus3 = tb_den ? tb_d : 32'hzzzz_zzzz;

    sram_responder #(.ADDR_W(8), .READ_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .ram_data(bus1), .ram_addr(addr), .ram_be_n(be_n),
        .ram_ce_n(ce_n), .ram_oe_n(oe_n), .ram_we_n(we_n),
        .wr_count(wr1), .rd_count(rd1), .conflict(conf1), .state_dbg(st1)
    );

    sram_responder #(.ADDR_W(8), .READ_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .ram_data(bus3), .ram_addr(addr), .ram_be_n(be_n),
        .ram_ce_n(ce_n), .ram_oe_n(oe_n), .ram_we_n(we_n),
        .wr_count(wr3), .rd_count(rd3), .conflict(conf3), .state_dbg(st3)
    );

    // Clock and edge counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: each entry into the drive state pops one expectation.
    always @(negedge clk) begin
        if (st1 == 2'd3 && prev1 != 2'd3) begin
            if (exp1_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL drive1_unexpected: got drive at edge %0d expected none", cyc);
            end else begin
                e1 = exp1_q.pop_front();
                check("drive1_edge", 32'(cyc[15:0]), 32'(e1[47:32]));
                check("drive1_data", bus1, e1[31:0]);
            end
        end
        if (st3 == 2'd3 && prev3 != 2'd3) begin
            if (exp3_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL drive3_unexpected: got drive at edge %0d expected none", cyc);
            end else begin
                e3 = exp3_q.pop_front();
                check("drive3_edge", 32'(cyc[15:0]), 32'(e3[47:32]));
                check("drive3_data", bus3, e3[31:0]);
            end
        end
        prev1 = st1;
        prev3 = st3;
    end

    // Driver tasks: each starts and ends 1 time unit after a rising edge.
    task automatic go_idle();
        ce_n = 1'b1; oe_n = 1'b1; we_n = 1'b1; tb_den = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // A DUT that is not driving leaves the bench's probe pattern intact.
    task automatic probe(input string name);
        tb_d = PROBE; tb_den = 1'b1;
        #1;
        check({name, "_bus1_released"}, bus1, PROBE);
        check({name, "_bus3_released"}, bus3, PROBE);
        tb_den = 1'b0;
    endtask

    task automatic write_word(input logic [19:0] a, input logic [31:0] d,
                              input logic [3:0] b, input logic oe);
        addr = a; be_n = b; tb_d = d; tb_den = 1'b1;
        ce_n = 1'b0; we_n = 1'b0; oe_n = oe;
        tick(1);
        go_idle();
        tick(1);
    endtask

    // Holds the request for 3 extra edges so both latencies reach the drive state.
    task automatic read_word(input logic [19:0] a, input logic [31:0] exp);
        addr = a; ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1; tb_den = 1'b0;
        tick(1);
        exp1_q.push_back({16'(cyc + 1), exp});
        exp3_q.push_back({16'(cyc + 3), exp});
        tick(3);
        go_idle();
        tick(1);
        probe("after_read");
    endtask

    initial begin
        rst = 1'b0;
        go_idle();
        addr = 20'd0; be_n = 4'hF; tb_d = 32'd0;
        #2;
        check("reset_wr1", 32'(wr1), 32'd0);
        check("reset_rd1", 32'(rd1), 32'd0);
        check("reset_conf1", 32'(conf1), 32'd0);
        check("reset_state1", 32'(st1), 32'd0);
        check("reset_wr3", 32'(wr3), 32'd0);
        probe("reset");
        @(negedge clk);
        rst = 1'b1;
        tick(1);

        // Full-word write then read.
        write_word(20'h00010, 32'hDEADBEEF, 4'h0, 1'b1);
        read_word(20'h00010, 32'hDEADBEEF);
        check("basic_wr1", 32'(wr1), 32'd1);
        check("basic_rd1", 32'(rd1), 32'd1);
        check("basic_rd3", 32'(rd3), 32'd1);

        // Byte-masked overwrite: bytes 0 and 2 are enabled.
        write_word(20'h00005, 32'h11223344, 4'h0, 1'b1);
        write_word(20'h00005, 32'hAABBCCDD, 4'b1010, 1'b1);
        read_word(20'h00005, 32'h11BB33DD);

        // Address aliasing modulo 256.
        write_word(20'h00100, 32'hCAFEF00D, 4'h0, 1'b1);
        read_word(20'h00000, 32'hCAFEF00D);

        // No-byte write still counts.
        write_word(20'h00005, 32'hFFFFFFFF, 4'hF, 1'b1);
        check("nobyte_wr1", 32'(wr1), 32'd5);
        read_word(20'h00005, 32'h11BB33DD);

        // Two-beat write burst: only the last beat is committed.
        write_word(20'h00009, 32'h99999999, 4'h0, 1'b1);
        addr = 20'h00009; be_n = 4'h0; tb_d = 32'h00000001; tb_den = 1'b1;
        ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1;
        tick(1);
        addr = 20'h0000A; tb_d = 32'h00000002;
        tick(1);
        go_idle();
        tick(1);
        check("burst_wr1", 32'(wr1), 32'd7);
        read_word(20'h0000A, 32'h00000002);
        read_word(20'h00009, 32'h99999999);

        // Address change one cycle into a read restarts the latency count.
        write_word(20'h00007, 32'h07070707, 4'h0, 1'b1);
        write_word(20'h00008, 32'h08080808, 4'h0, 1'b1);
        addr = 20'h00007; ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1;
        tick(1);
        addr = 20'h00008;
        exp1_q.push_back({16'(cyc + 2), 32'h08080808});
        exp3_q.push_back({16'(cyc + 4), 32'h08080808});
        tick(4);
        go_idle();
        tick(1);
        probe("restart");
        check("restart_rd1", 32'(rd1), 32'd7);
        check("restart_rd3", 32'(rd3), 32'd7);
        check("restart_wr3", 32'(wr3), 32'd9);

        // Conflict cycle: ce_n=oe_n=we_n=0, handled as a write.
        write_word(20'h00014, 32'h12345678, 4'h0, 1'b0);
        check("conflict_set1", 32'(conf1), 32'(EXP_CONF));
        check("conflict_wr1", 32'(wr1), 32'd10);
        read_word(20'h00014, 32'h12345678);
        tick(2);
        check("conflict_hold1", 32'(conf1), 32'(EXP_CONF));
        check("conflict_hold3", 32'(conf3), 32'(EXP_CONF));

        // Reset asserted mid-write discards the pending write.
        addr = 20'h0000A; be_n = 4'h0; tb_d = 32'hFFFFFFFF; tb_den = 1'b1;
        ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1;
        tick(1);
        #2;
        rst = 1'b0;
        #1;
        check("midwr_reset_wr1", 32'(wr1), 32'd0);
        check("midwr_reset_rd1", 32'(rd1), 32'd0);
        check("midwr_reset_conf1", 32'(conf1), 32'd0);
        check("midwr_reset_state1", 32'(st1), 32'd0);
        check("midwr_reset_rd3", 32'(rd3), 32'd0);
        go_idle();
        probe("midwr_reset");
        @(negedge clk);
        rst = 1'b1;
        tick(1);
        read_word(20'h0000A, 32'h00000002);
        check("post_reset_wr1", 32'(wr1), 32'd0);
        check("post_reset_rd1", 32'(rd1), 32'd1);
        check("post_reset_conf1", 32'(conf1), 32'd0);

        tick(3);
        check("pending_q1", 32'(exp1_q.size()), 32'd0);
        check("pending_q3", 32'(exp3_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_responder.md
SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning the storage depth is 2^ADDR_W 32-bit words.
REQ-002 SHALL have parameter READ_LAT, default 1, legal range 1-4, meaning cycles from a read request being sampled to data being driven.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port ram_data, inout, 32: read data driven out, write data sampled in.
REQ-006 SHALL have port ram_addr, input, 20: word address.
REQ-007 SHALL have port ram_be_n, input, 4: byte enables, active-low, bit i covers data[8i+7:8i].
REQ-008 SHALL have ports ram_ce_n, ram_oe_n and ram_we_n, input, 1 each: chip select, output enable and write enable, all active-low.
REQ-009 SHALL have ports wr_count and rd_count, output, 16 each: committed-write and served-read counters.
REQ-010 SHALL have port conflict, output, 1: sticky bus-conflict flag.

Function
REQ-011 SHALL sample ram_addr, ram_be_n, ram_ce_n, ram_oe_n, ram_we_n and ram_data on every rising clk edge; all decisions use the sampled values.
REQ-012 SHALL index storage with ram_addr[ADDR_W-1:0] only; upper address bits are ignored, so addresses alias modulo 2^ADDR_W.
REQ-013 SHALL implement states IDLE, WRITE, READ_WAIT and READ_DRIVE.
REQ-014 SHALL, in IDLE, go to WRITE when ce_n=0 and we_n=0.
REQ-015 SHALL, in IDLE, go to READ_WAIT when ce_n=0, oe_n=0 and we_n=1, loading the latency counter with READ_LAT-1.
REQ-016 SHALL, in IDLE, otherwise stay in IDLE.
REQ-017 SHALL, in WRITE, re-capture addr, be_n and data every cycle in which ce_n=0 and we_n=0.
REQ-018 SHALL, on the first sampled cycle in WRITE with we_n=1 or ce_n=1, commit the last captured data to the last captured address for bytes whose be_n bit is 0.
REQ-019 SHALL, on that commit cycle, increment wr_count and return to IDLE.
REQ-020 SHALL treat a write with be_n=4'hF as a commit that changes no byte but still increments wr_count.
REQ-021 SHALL, in READ_WAIT, decrement the counter each cycle and move to READ_DRIVE when it reaches 0; with READ_LAT=1 this is the next cycle.
REQ-022 SHALL, on entering READ_DRIVE, increment rd_count.
REQ-023 SHALL, in READ_DRIVE, drive mem[addr] onto ram_data; otherwise ram_data SHALL be high-Z.
REQ-024 SHALL, in READ_WAIT or READ_DRIVE, restart READ_WAIT with a reloaded counter if the sampled address changes; rd_count increments again on the next READ_DRIVE entry.
REQ-025 SHALL, in READ_WAIT or READ_DRIVE, release ram_data and go to IDLE in the same edge when ce_n=1 or oe_n=1.
REQ-026 SHALL, in READ_WAIT or READ_DRIVE, go to IDLE when we_n=0; the write is then detected from IDLE on the following cycle.
REQ-027 SHALL return new data for a read of an address written by a write committed on an earlier edge (no stale-read hazard).
REQ-028 SHALL saturate wr_count and rd_count at 16'hFFFF; they do not wrap.

Reset
REQ-029 SHALL, while rst=0, force state IDLE, wr_count=0, rd_count=0, conflict=0 and ram_data high-Z, independent of clk.
REQ-030 SHALL discard a pending uncommitted write when reset asserts mid-WRITE; storage contents are not cleared by reset.
REQ-031 SHALL release reset synchronously to the next rising clk edge before any state transition.

Configuration
REQ-032 SHALL, with macro SRAM_RESP_CONFLICT_EN defined, set conflict to 1 on any sampled cycle with ce_n=0, oe_n=0 and we_n=0.
REQ-033 SHALL, with SRAM_RESP_CONFLICT_EN defined, hold conflict at 1 until reset; that cycle is otherwise handled as a write.
REQ-034 SHALL, without SRAM_RESP_CONFLICT_EN, tie conflict to 0 and synthesize no detection logic.

Verification
REQ-035 SHALL cover: write 32'hDEADBEEF to address 0x00010, be_n=0, then read it with READ_LAT=1 -> ram_data=32'hDEADBEEF one cycle after the read is sampled; wr_count=1, rd_count=1.
REQ-036 SHALL cover: write 32'h11223344 to address 5, then write 32'hAABBCCDD to address 5 with be_n=4'b1010, then read -> 32'h11BB33DD.
REQ-037 SHALL cover: write 32'hCAFEF00D to address 0x00100 with ADDR_W=8, then read address 0x00000 -> 32'hCAFEF00D (aliasing).
REQ-038 SHALL cover: with READ_LAT=3, read address 7, then change the address to 8 after 1 cycle -> no drive until 3 cycles after the change, and rd_count increments once.
REQ-039 SHALL cover: assert rst mid-WRITE before we_n rises -> storage is unchanged, wr_count=0, ram_data is high-Z.
REQ-040 SHALL cover: drive ce_n=oe_n=we_n=0 for one cycle -> with the macro, conflict=1 and stays 1 until rst; without the macro, conflict=0.
